csa_coeff_adder_tree: RTL and testbench
=======================================

Name: csa_coeff_adder_tree

Overview:
Pipelined carry-save adder tree that sums a fixed table of CGES signed coefficients. Coefficient 0 is always included. Coefficient i (i ≥ 1) is included only when select bit cges[i] is set. The result is a redundant sum/carry pair (vs, vc). A downstream carry-propagate adder forms the final total vs+vc.

Parameters:
- BITS, 32, width of each signed coefficient.
- CGES, 13, number of coefficients; must be ≥ 3.
- MAX, $clog2(CGES)+BITS (36), width of the operands inside the tree and of the outputs.
- INPUT, 7, fan-in of each carry-save compressor group; must be ≥ 3.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset; clears every pipeline register.
- en  in  1  pipeline advance enable.
- cges  in  [CGES-1:1]  per-coefficient include mask.
- vs  out  [MAX-1:0]  registered sum vector.
- vc  out  [MAX-1:0]  registered carry vector.

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). While reset is asserted, all registers are 0, so vs = vc = 0.
- Coefficient ROM (32-bit two's complement, index 0..12), fixed constants:
  - 0x00045434, 0x00008CB4, 0x0000C684, 0xFFFD35F0,
  - 0x00016E40, 0x000188F8, 0x0004982C, 0x000010D4,
  - 0x0001392A, 0x00000772, 0x00005D20, 0xFFFFBF78,
  - 0xFFFEB844.
- Operand k = sign_extend_MAX(C[k] & {BITS{cges[k]}}). Operand 0 is ungated.
- Level schedule, starting with n = CGES, repeated while n ≥ INPUT:
  - d = n / INPUT groups.
  - Operands [INPUT*g .. INPUT*g+INPUT-1] feed compressor g. Its sum goes to slot g and its carry to slot d+g.
  - The n mod INPUT leftover operands are bypassed to slots 2d, 2d+1, ….
  - Every slot is registered; this is one pipeline stage.
  - The next n is 2d + (n mod INPUT).
- Final step after the loop:
  - If n > 2: one N-to-2 compressor over all n operands, registered; this adds one stage.
  - If n == 2: slot 0 drives vs and slot 1 drives vc directly from the last stage.
- Defaults (13 → 8 → 3 → 2): 3 stages, so latency is 3 cycles with en held high.
- Compressor:
  - Built from repeated 3:2 full-adder layers.
  - Carries are shifted left by 1; bits above MAX-1 are discarded.
  - Invariant: vs + vc ≡ Σ inputs (mod 2^MAX).
  - The exact vs/vc bit split is implementation-defined; verification checks only (vs+vc) mod 2^MAX.
- en = 0: all registers hold and the outputs are frozen. A change on cges has no effect until en rises.
- The tree is fully pipelined: with en high, a new cges value is accepted every cycle.
- Reset asserted mid-stream flushes every stage to 0. After release, valid results reappear only after the full latency.
- Signed overflow cannot occur: MAX bits hold the sum of CGES values of BITS bits each.

Decomposition:
- Shared package holds:
  - constants BITS, CGES, INPUT and derived MAX;
  - the coefficient ROM array;
  - a constant function returning the per-level operand count and the number of stages (used for generate bounds and by the bench to compute latency).
- One natural sub-module: csa_compress_n (parameters W, N; input N*W packed bus; outputs sum and carry, W bits each; purely combinational).
- Pipeline registers, gating and sign extension are written inline.

Test Plan:
- Reset: assert reset with en=1 and random cges → vs=0, vc=0 immediately and for every cycle reset stays high.
- Base coefficient only: cges=0, en=1, after 3 cycles → (vs+vc) mod 2^36 = 283700 (0x000045434).
- All selected: cges = all ones → after 3 cycles vs+vc = 693004.
- Negative coefficients: cges with only bit 3 set → 100900; cges with bits 3, 11 and 12 set → 480. Both cases exercise sign extension and carry wrap.
- Throughput and stall:
  - Drive the three masks above on consecutive cycles → results appear on consecutive cycles 3 cycles later.
  - Drop en for 2 cycles mid-stream → outputs freeze, and the sequence resumes without loss or duplication.
- Reset mid-operation: pulse reset between masks → outputs go to 0 at once. Only masks applied after release produce results, after 3 en-high cycles.

Source files
------------

// File: rtl/csa_coeff_adder_tree_pkg.sv
// Shared constants, coefficient ROM and level-schedule helpers for the
// carry-save coefficient adder tree.
package csa_coeff_adder_tree_pkg;

    // Width of each signed coefficient.
    localparam int BITS  = 32;
    // Number of coefficients; coefficient 0 is always included.
    localparam int CGES  = 13;
    // Fan-in of each carry-save compressor group.
    localparam int INPUT = 7;
    // Operand width inside the tree: room for CGES values of BITS bits each.
    localparam int MAX   = $clog2(CGES) + BITS;

    // Fixed coefficient table, two's complement.
    localparam logic [BITS-1:0] COEFF [CGES] = '{
        32'h00045434, 32'h00008CB4, 32'h0000C684, 32'hFFFD35F0,
        32'h00016E40, 32'h000188F8, 32'h0004982C, 32'h000010D4,
        32'h0001392A, 32'h00000772, 32'h00005D20, 32'hFFFFBF78,
        32'hFFFEB844
    };

    // Operand count entering pipeline level lvl (level 0 sees all CGES).
    // Once n drops below INPUT the recurrence is a fixed point, so asking for
    // a level past the last one simply returns the final count.
    function automatic int level_n(input int lvl);
        int n;
        n = CGES;
        for (int i = 0; i < lvl; i++) begin
            n = 2 * (n / INPUT) + (n % INPUT);
        end
        return n;
    endfunction

    // Number of INPUT-wide compressor levels before the final reduction.
    function automatic int num_levels();
        int n;
        int cnt;
        n   = CGES;
        cnt = 0;
        while (n >= INPUT) begin
            n   = 2 * (n / INPUT) + (n % INPUT);
            cnt = cnt + 1;
        end
        return cnt;
    endfunction

    // Total register stages from cges to vs/vc (the pipeline latency).
    function automatic int num_stages();
        int lv;
        lv = num_levels();
        return lv + ((level_n(lv) > 2) ? 1 : 0);
    endfunction

endpackage

// File: rtl/csa_compress_n.sv
// Purely combinational N-to-2 carry-save compressor built from repeated
// layers of 3:2 full adders. The output pair satisfies
// sum + carry == sum of all inputs (mod 2^W).
module csa_compress_n #(
    parameter int W = 36,
    parameter int N = 7
) (
    input  logic [N*W-1:0] in_bus,
    output logic [W-1:0]   sum,
    output logic [W-1:0]   carry
);

    logic [W-1:0] work [N];
    logic [W-1:0] nxt  [N];
    int           cnt;
    int           groups;
    int           rem;

    // Reduce operands three at a time until two remain; each layer turns every
    // full triple into a sum word plus a left-shifted carry word, and passes
    // the 0..2 leftovers straight through. Carry bits beyond W-1 fall off.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            work[i] = in_bus[i*W +: W];
            nxt[i]  = '0;
        end
        cnt    = N;
        groups = 0;
        rem    = 0;
        for (int it = 0; it < N; it++) begin
            if (cnt > 2) begin
                groups = cnt / 3;
                rem    = cnt % 3;
                for (int j = 0; j < N; j++) begin
                    nxt[j] = '0;
                end
                for (int g = 0; g < N / 3; g++) begin
                    if (g < groups) begin
                        nxt[g]        = work[3*g] ^ work[3*g+1] ^ work[3*g+2];
                        nxt[groups+g] = ((work[3*g]   & work[3*g+1]) |
                                         (work[3*g]   & work[3*g+2]) |
                                         (work[3*g+1] & work[3*g+2])) << 1;
                    end
                end
                for (int j = 0; j < 2; j++) begin
                    if (j < rem) begin
                        nxt[2*groups+j] = work[3*groups+j];
                    end
                end
                for (int j = 0; j < N; j++) begin
                    work[j] = nxt[j];
                end
                cnt = 2 * groups + rem;
            end
        end
        sum   = work[0];
        carry = work[1];
    end

endmodule

// File: rtl/csa_coeff_adder_tree.sv
// Pipelined carry-save adder tree summing the selected coefficients from the
// package ROM. Output is a redundant (vs, vc) pair; a downstream CPA forms
// vs + vc. Every stage advances only while en is high.
module csa_coeff_adder_tree
    import csa_coeff_adder_tree_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [CGES-1:1] cges,
    output logic [MAX-1:0]  vs,
    output logic [MAX-1:0]  vc
);

    localparam int NUM_LVL = num_levels();
    localparam int LAST_N  = level_n(NUM_LVL);

    // Coefficient 0 is always part of the sum.
    logic [CGES-1:0]     sel;
    logic [CGES*MAX-1:0] operands;

    assign sel = {cges, 1'b1};

    // Gate each coefficient by its select bit and sign-extend to MAX bits.
    for (genvar k = 0; k < CGES; k++) begin : g_op
        logic [BITS-1:0] masked;
        assign masked = COEFF[k] & {BITS{sel[k]}};
        assign operands[k*MAX +: MAX] = {{(MAX-BITS){masked[BITS-1]}}, masked};
    end

    // One registered level per iteration of the INPUT-wide schedule.
    for (genvar L = 0; L < NUM_LVL; L++) begin : g_lvl
        localparam int N_IN  = level_n(L);
        localparam int D     = N_IN / INPUT;
        localparam int R     = N_IN % INPUT;
        localparam int N_OUT = 2 * D + R;

        logic [N_IN*MAX-1:0]  in_bus;
        logic [N_OUT*MAX-1:0] stage_d;
        logic [N_OUT*MAX-1:0] stage_q;
        logic [MAX-1:0]       cmp_sum   [D];
        logic [MAX-1:0]       cmp_carry [D];

        if (L == 0) begin : g_src
            assign in_bus = operands;
        end else begin : g_src
            assign in_bus = g_lvl[L-1].stage_q;
        end

        for (genvar g = 0; g < D; g++) begin : g_cmp
            csa_compress_n #(
                .W (MAX),
                .N (INPUT)
            ) u_cmp (
                .in_bus (in_bus[INPUT*g*MAX +: INPUT*MAX]),
                .sum    (cmp_sum[g]),
                .carry  (cmp_carry[g])
            );
        end

        // Slot layout: sums at 0..D-1, carries at D..2D-1, leftovers after.
        always_comb begin
            stage_d = '0;
            for (int g = 0; g < D; g++) begin
                stage_d[g*MAX +: MAX]     = cmp_sum[g];
                stage_d[(D+g)*MAX +: MAX] = cmp_carry[g];
            end
            for (int j = 0; j < R; j++) begin
                stage_d[(2*D+j)*MAX +: MAX] = in_bus[(INPUT*D+j)*MAX +: MAX];
            end
        end

        // Level register: cleared by reset, holds while en is low.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                stage_q <= '0;
            end else if (en) begin
                stage_q <= stage_d;
            end
        end
    end

    // Operands left after the schedule, fed to the final reduction.
    logic [LAST_N*MAX-1:0] last_bus;

    if (NUM_LVL == 0) begin : g_last_src
        assign last_bus = operands;
    end else begin : g_last_src
        assign last_bus = g_lvl[NUM_LVL-1].stage_q;
    end

    if (LAST_N > 2) begin : g_final
        logic [MAX-1:0] fin_sum;
        logic [MAX-1:0] fin_carry;
        logic [MAX-1:0] vs_d;
        logic [MAX-1:0] vc_d;
        logic [MAX-1:0] vs_q;
        logic [MAX-1:0] vc_q;

        csa_compress_n #(
            .W (MAX),
            .N (LAST_N)
        ) u_final (
            .in_bus (last_bus),
            .sum    (fin_sum),
            .carry  (fin_carry)
        );

        // Next output pair comes straight from the final compressor.
        always_comb begin
            vs_d = fin_sum;
            vc_d = fin_carry;
        end

        // Output register stage: cleared by reset, holds while en is low.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                vs_q <= '0;
                vc_q <= '0;
            end else if (en) begin
                vs_q <= vs_d;
                vc_q <= vc_d;
            end
        end

        assign vs = vs_q;
        assign vc = vc_q;
    end else begin : g_final
        // Exactly two slots remain: they already form the redundant pair.
        assign vs = last_bus[0 +: MAX];
        assign vc = last_bus[MAX +: MAX];
    end

endmodule

// File: tb/tb_csa_coeff_adder_tree.sv
// Directed self-checking bench for csa_coeff_adder_tree: checks the
// resolved total (vs + vc) mod 2^MAX against hand-computed coefficient sums.
module tb_csa_coeff_adder_tree;
  import csa_coeff_adder_tree_pkg::*;

  localparam int LAT = num_stages();

  // Hand-computed totals for the masks used below (mask bit k = coefficient k).
  localparam logic [CGES-1:0] M_BASE  = 13'h0000;
  localparam logic [CGES-1:0] M_ALL   = 13'h1FFE;
  localparam logic [CGES-1:0] M_B3    = 13'h0008;
  localparam logic [CGES-1:0] M_NEG3  = 13'h1808;
  localparam logic [CGES-1:0] M_B12   = 13'h1000;
  localparam logic [CGES-1:0] M_B6    = 13'h0040;
  localparam logic [MAX-1:0]  S_BASE  = 36'd283700;
  localparam logic [MAX-1:0]  S_ALL   = 36'd693004;
  localparam logic [MAX-1:0]  S_B3    = 36'd100900;
  localparam logic [MAX-1:0]  S_NEG3  = 36'd480;
  localparam logic [MAX-1:0]  S_B12   = 36'd199800;
  localparam logic [MAX-1:0]  S_B6    = 36'd584800;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [CGES-1:1] cges;
  logic [MAX-1:0]  vs;
  logic [MAX-1:0]  vc;
  logic [MAX-1:0]  tot;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  assign tot = vs + vc;

  csa_coeff_adder_tree dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .cges  (cges),
    .vs    (vs),
    .vc    (vc)
  );

  // ---------------- driver tasks ----------------
  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_mask(input logic [CGES-1:0] m);
    cges = m[CGES-1:1];
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    en    = 1'b1;
    cges  = CGES'($urandom_range(0, 4095)) >> 1;
    #1;
    checks++;
    if (vs !== '0 || vc !== '0) begin
      failures++;
      $display("FAIL reset_initial: vs=%h vc=%h expected 0/0", vs, vc);
    end
    for (int i = 0; i < 4; i++) begin
      cges = (CGES-1)'($urandom_range(0, 4095));
      cycle();
      checks++;
      if (vs !== '0 || vc !== '0) begin
        failures++;
        $display("FAIL reset_held[%0d]: vs=%h vc=%h expected 0/0", i, vs, vc);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_base_latency();
    drive_mask(M_BASE);
    en = 1'b1;
    for (int i = 0; i < LAT - 1; i++) begin
      cycle();
      checks++;
      if (tot !== '0) begin
        failures++;
        $display("FAIL base_early[%0d]: total=%0d expected 0", i, tot);
      end
    end
    cycle();
    checks++;
    if (tot !== S_BASE) begin
      failures++;
      $display("FAIL base_only: total=%0d expected %0d", tot, S_BASE);
    end
  endtask

  task automatic test_all_selected();
    drive_mask(M_ALL);
    for (int i = 0; i < LAT; i++) cycle();
    checks++;
    if (tot !== S_ALL) begin
      failures++;
      $display("FAIL all_selected: total=%0d expected %0d", tot, S_ALL);
    end
  endtask

  task automatic test_negative();
    drive_mask(M_B3);
    for (int i = 0; i < LAT; i++) cycle();
    checks++;
    if (tot !== S_B3) begin
      failures++;
      $display("FAIL neg_bit3: total=%0d expected %0d", tot, S_B3);
    end
    drive_mask(M_NEG3);
    for (int i = 0; i < LAT; i++) cycle();
    checks++;
    if (tot !== S_NEG3) begin
      failures++;
      $display("FAIL neg_bits_3_11_12: total=%0d expected %0d", tot, S_NEG3);
    end
  endtask

  task automatic test_back_to_back();
    logic [CGES-1:0] m [3];
    logic [MAX-1:0]  e [3];
    m = '{M_BASE, M_ALL, M_B3};
    e = '{S_BASE, S_ALL, S_B3};
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_mask(m[(i < 2) ? i : 2]);
      cycle();
      if (i >= LAT - 1) begin
        checks++;
        if (tot !== e[i-(LAT-1)]) begin
          failures++;
          $display("FAIL back_to_back[%0d]: total=%0d expected %0d", i - (LAT - 1), tot, e[i-(LAT-1)]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [CGES-1:0] sm [9];
    logic [MAX-1:0]  ss [9];
    logic            se [9];
    logic [MAX-1:0]  exp_q [$];
    // Prime every stage with one known total.
    drive_mask(M_B12);
    en = 1'b1;
    for (int i = 0; i < LAT; i++) cycle();
    exp_q = {};
    for (int i = 0; i < LAT; i++) exp_q.push_back(S_B12);
    sm = '{M_B6, M_NEG3, M_ALL, M_B3, M_BASE, M_ALL, M_ALL, M_ALL, M_ALL};
    ss = '{S_B6, S_NEG3, S_ALL, S_B3, S_BASE, S_ALL, S_ALL, S_ALL, S_ALL};
    se = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      drive_mask(sm[i]);
      en = se[i];
      cycle();
      // exp_q[0] is the oldest entry, i.e. what the output stage holds.
      if (se[i]) begin
        void'(exp_q.pop_front());
        exp_q.push_back(ss[i]);
      end
      checks++;
      if (tot !== exp_q[0]) begin
        failures++;
        $display("FAIL stall_step[%0d]: total=%0d expected %0d", i, tot, exp_q[0]);
      end
    end
    en = 1'b1;
  endtask

  task automatic test_reset_mid();
    drive_mask(M_ALL);
    en = 1'b1;
    for (int i = 0; i < LAT; i++) cycle();
    checks++;
    if (tot !== S_ALL) begin
      failures++;
      $display("FAIL rmid_before: total=%0d expected %0d", tot, S_ALL);
    end
    drive_mask(M_B3);
    cycle();
    // Asynchronous assertion between edges must clear the outputs at once.
    reset = 1'b1;
    #2;
    checks++;
    if (vs !== '0 || vc !== '0) begin
      failures++;
      $display("FAIL rmid_async: vs=%h vc=%h expected 0/0", vs, vc);
    end
    cycle();
    checks++;
    if (vs !== '0 || vc !== '0) begin
      failures++;
      $display("FAIL rmid_held: vs=%h vc=%h expected 0/0", vs, vc);
    end
    reset = 1'b0;
    drive_mask(M_B6);
    for (int i = 0; i < LAT - 1; i++) begin
      cycle();
      checks++;
      if (tot !== '0) begin
        failures++;
        $display("FAIL rmid_flushed[%0d]: total=%0d expected 0", i, tot);
      end
    end
    cycle();
    checks++;
    if (tot !== S_B6) begin
      failures++;
      $display("FAIL rmid_after: total=%0d expected %0d", tot, S_B6);
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    reset = 1'b1;
    en    = 1'b0;
    cges  = '0;
    checks++;
    if (LAT !== 3) begin
      failures++;
      $display("FAIL latency_param: stages=%0d expected 3", LAT);
    end
    test_reset();
    test_base_latency();
    test_all_selected();
    test_negative();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
